// File: rtl/dmem_responder.sv
// dmem_responder: memory-side responder between the LSU and on-chip data RAM.
// It handles one word-aligned request at a time, either a byte-strobed write or
// a full-word read, and returns the raw 32-bit word.
//   clk, rst_n          : clock, synchronous active-low reset
//   req_valid/req_ready : request handshake (ready only while IDLE and out of reset)
//   req_we, req_addr    : 1 = write / 0 = read, byte address
//   req_wstrb, req_wdata: byte-lane enables and lane-aligned data (writes only)
//   rsp_valid/rsp_ready : response handshake
//   rsp_rdata, rsp_err  : read word (0 for writes/errors), range/alignment error
module dmem_responder #(
   parameter int MEM_BYTES    = 4096,
   parameter int READ_LATENCY = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [3:0]  req_wstrb,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);

   localparam int WORDS = MEM_BYTES / 4;
   localparam int AW    = (WORDS > 1) ? $clog2(WORDS) : 1;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t          state, state_d;
   logic [2:0]      cnt, cnt_d;
   logic [AW-1:0]   addr_q;
   logic [AW-1:0]   req_idx;
   logic [31:0]     mem [WORDS];
   logic            accept;
   logic            req_err;
   logic            load_rsp;
   logic [31:0]     rdata_d;
   logic            err_d;

   // req_ready includes rst_n so that nothing is accepted (and no RAM write
   // happens) on an edge where reset is asserted.
   assign req_ready = (state == IDLE) && rst_n;
   assign accept    = req_valid && req_ready;
   assign req_err   = (req_addr >= 32'(MEM_BYTES)) || (req_addr[1:0] != 2'b00);
   assign req_idx   = req_addr[AW+1:2];
   assign rsp_valid = (state == RESP);

   always_comb begin
      state_d  = state;
      cnt_d    = cnt;
      load_rsp = 1'b0;
      rdata_d  = 32'h0;
      err_d    = 1'b0;
      case (state)
         IDLE: begin
            if (accept) begin
               if (req_we || req_err || (READ_LATENCY == 1)) begin
                  state_d  = RESP;
                  load_rsp = 1'b1;
                  err_d    = req_err;
                  // Only a good single-cycle read returns data; RAM is read
                  // before this edge's write, but a write never reaches here
                  // as a read, so there is no same-edge hazard.
                  if (!req_we && !req_err)
                     rdata_d = mem[req_idx];
               end else begin
                  state_d = WAIT;
                  cnt_d   = 3'd1;
               end
            end
         end
         WAIT: begin
            cnt_d = cnt + 3'd1;
            if (cnt == 3'(READ_LATENCY - 1)) begin
               state_d  = RESP;
               cnt_d    = 3'd0;
               load_rsp = 1'b1;
               rdata_d  = mem[addr_q];
            end
         end
         RESP: begin
            // Leaving RESP reloads the response registers with zeros.
            if (rsp_ready) begin
               state_d  = IDLE;
               load_rsp = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= 3'd0;
         addr_q    <= '0;
         rsp_rdata <= 32'h0;
         rsp_err   <= 1'b0;
      end else begin
         state <= state_d;
         cnt   <= cnt_d;
         if (accept)
            addr_q <= req_idx;
         if (load_rsp) begin
            rsp_rdata <= rdata_d;
            rsp_err   <= err_d;
         end
      end
   end

   // RAM contents are deliberately not reset.
   always_ff @(posedge clk) begin
      if (accept && req_we && !req_err) begin
         for (int i = 0; i < 4; i++)
            if (req_wstrb[i])
               mem[req_idx][8*i +: 8] <= req_wdata[8*i +: 8];
      end
   end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Memory-side responder for the core's load/store path; sits between the load/store unit and on-chip data RAM.
- Accepts one word-aligned request at a time: a byte-strobed write (lane-aligned data + wstrb, as produced by the LSU) or a full-word read.
- Returns the raw 32-bit word for the LSU to extract and extend. Writes have 1-cycle latency; read latency is configurable.
- Flags out-of-range and misaligned requests with an error response.

Parameters:
MEM_BYTES, 4096, RAM size in bytes; multiple of 4.
READ_LATENCY, 2, cycles from request acceptance to read response; legal 1..4.

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  synchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  responder can accept a request
req_we  input  1  1 = write, 0 = read
req_addr  input  32  byte address
req_wstrb  input  4  byte-lane write enables; ignored for reads
req_wdata  input  32  lane-aligned write data
rsp_valid  output  1  response present
rsp_ready  input  1  requester accepts response
rsp_rdata  output  32  read word; 0 for writes and errors
rsp_err  output  1  request was out of range or misaligned

Behaviour:
- Reset: sampled on a rising clk edge with rst_n=0. Forces state IDLE, rsp_valid=0, rsp_err=0, rsp_rdata=0 and clears the latency counter. RAM contents are not reset.
- Reset mid-operation: a pending request or response is dropped silently, and no RAM write occurs on that edge.
- req_ready = (state==IDLE) && rst_n. It is combinational, so req_ready=1 in the first cycle after reset is released.
- Accept: on an edge with req_valid && req_ready. Only one request is outstanding; there is no pipelining.
- Error check at accept: err = (req_addr >= MEM_BYTES) || (req_addr[1:0] != 0).
- Write, no error: bytes i with req_wstrb[i]=1 are written at word req_addr[31:2] from req_wdata[8i+7:8i], on the accept edge. Other bytes are unchanged.
- Write with wstrb=0: no RAM change; normal (non-error) response.
- Error request: no RAM change; response has rsp_err=1 and rsp_rdata=0.
- FSM states:
  - IDLE: on accept, go to RESP if req_we, err, or READ_LATENCY=1; otherwise go to WAIT with cnt=1.
  - WAIT: cnt increments each edge; at cnt==READ_LATENCY-1, go to RESP.
  - RESP: rsp_valid=1. On an edge with rsp_ready=1, go to IDLE.
- Timing: for a request accepted at edge N, rsp_valid rises after edge N+1 for writes and errors, and after edge N+READ_LATENCY for good reads.
- Read data: the RAM word is captured into rsp_rdata on the edge that enters RESP.
  - A write accepted earlier is visible to a later read (read-after-write).
  - rsp_rdata and rsp_err stay stable while rsp_valid && !rsp_ready.
- Back-to-back throughput: req_ready returns the cycle after the response handshake. Peak rate is one request per READ_LATENCY+1 cycles for reads and 2 cycles for writes.
- Outputs are cleared to 0 on the edge leaving RESP.

Test Plan:
- Reset then SW: addr=0x10, wstrb=1111, wdata=0xFEDC_BA98. Expect rsp_valid 1 cycle after accept, err=0, rdata=0. A following read of 0x10 returns 0xFEDC_BA98 exactly 2 cycles after its accept (READ_LATENCY=2).
- Byte-lane merge: SB wstrb=0010, wdata=0x0000_7800, then SH wstrb=1100, wdata=0xEF01_0000, both to 0x10. Read 0x10 returns 0xEF01_7898.
- Backpressure: read of 0x10 with rsp_ready held 0 for 5 cycles. rsp_valid stays 1, rdata is stable at 0xEF01_7898, and req_ready=0 throughout. Raise rsp_ready; the next cycle has req_ready=1.
- Errors:
  - Write to addr=0x1002: err=1, no RAM change.
  - Read at MEM_BYTES (0x1000): err=1, rdata=0, response 1 cycle after accept.
  - Read of 0x10 afterwards still returns 0xEF01_7898.
- wstrb=0000 write to 0x10 with wdata=0xFFFF_FFFF: err=0, and 0x10 is unchanged.
- Reset mid-read: assert rst_n=0 during WAIT. rsp_valid never rises and req_ready=1 the cycle after rst_n=1. Repeat with READ_LATENCY=1: reads respond 1 cycle after accept.
